// File: rtl/uart_tx_cfg_if.sv
// Word handshake between a producer and uart_tx_cfg: data qualified by start, accepted when ready.
interface uart_tx_cfg_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data;
   logic                 start;
   logic                 ready;

   modport master (output data, output start, input  ready);
   modport slave  (input  data, input  start, output ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_BITS LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO in front of the framer.
//
//   state   | meaning
//   S_IDLE  | line idle high, waiting for a word
//   S_START | start bit (0) on the line
//   S_DATA  | data bits, LSB first; bit_q is the bit index
//   S_PAR   | parity bit on the line
//   S_STOP  | stop bits (1); bit_q counts stop bits
module uart_tx_cfg #(
   parameter int CLK_DIV    = 104,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rstn,
   uart_tx_cfg_if.slave bus,
   output logic         tx_o,
   output logic         busy_o
);
   localparam int BW = $clog2(CLK_DIV);

   if (CLK_DIV < 2 || CLK_DIV > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
       PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
      $error("uart_tx_cfg: illegal parameter set");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   state_t               state_q;
   logic [BW-1:0]        baud_q;
   logic [3:0]           bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_q;
   logic                 tx_q;
   logic                 bit_end;
   logic                 frame_free;
   logic                 load;
   logic                 ready;
   logic [DATA_BITS-1:0] load_data;

   assign bit_end    = (baud_q == BW'(CLK_DIV - 1));
   // Framer can take a new word when idle or in the very last cycle of the last stop bit.
   assign frame_free = (state_q == S_IDLE) ||
                       (state_q == S_STOP && bit_q == 4'(STOP_BITS - 1) && bit_end);
   assign bus.ready  = ready;
   assign tx_o       = tx_q;

`ifdef UART_TX_FIFO_EN
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]        wr_q;
   logic [PW-1:0]        rd_q;
   logic [PW:0]          cnt_q;
   logic                 push;

   assign ready     = (cnt_q != (PW + 1)'(FIFO_DEPTH));
   assign push      = bus.start && ready;
   assign load      = frame_free && (cnt_q != '0);
   assign load_data = mem_q[rd_q];
   assign busy_o    = (state_q != S_IDLE) || (cnt_q != '0);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + 1'b1;
         if (load) rd_q <= rd_q + 1'b1;
         case ({push, load})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= bus.data;
   end
`else
   assign ready     = frame_free;
   assign load      = bus.start && frame_free;
   assign load_data = bus.data;
   assign busy_o    = (state_q != S_IDLE);
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else if (load) begin
         state_q <= S_START;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= load_data;
         par_q   <= (^load_data) ^ (PARITY == 1);
         tx_q    <= 1'b0;
      end else if (state_q != S_IDLE) begin
         if (!bit_end) begin
            baud_q <= baud_q + 1'b1;
         end else begin
            baud_q <= '0;
            case (state_q)
               S_START: begin
                  state_q <= S_DATA;
                  tx_q    <= shift_q[0];
                  shift_q <= shift_q >> 1;
               end
               S_DATA: begin
                  if (bit_q == 4'(DATA_BITS - 1)) begin
                     bit_q <= '0;
                     if (PARITY != 0) begin
                        state_q <= S_PAR;
                        tx_q    <= par_q;
                     end else begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                     end
                  end else begin
                     bit_q   <= bit_q + 1'b1;
                     tx_q    <= shift_q[0];
                     shift_q <= shift_q >> 1;
                  end
               end
               S_PAR: begin
                  state_q <= S_STOP;
                  tx_q    <= 1'b1;
               end
               S_STOP: begin
                  if (bit_q == 4'(STOP_BITS - 1)) begin
                     state_q <= S_IDLE;
                     bit_q   <= '0;
                  end else begin
                     bit_q <= bit_q + 1'b1;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: five parameter sets run side by side, each checked every cycle
// against a frame-level reference of the serial line, plus hand-computed frame literals.
module tb_uart_tx_cfg;
   localparam int N       = 5;
   localparam int CD [N]  = '{4, 4, 4, 4, 3};
   localparam int DB [N]  = '{8, 8, 8, 7, 9};
   localparam int PA [N]  = '{0, 2, 1, 0, 1};
   localparam int SB [N]  = '{1, 1, 1, 2, 2};
   localparam int BL [N]  = '{40, 44, 44, 40, 39};
   localparam int FD      = 4;

   logic         clk  = 1'b0;
   logic         rstn = 1'b0;
   logic [8:0]   data_d [N];
   logic [N-1:0] start_d;
   logic [N-1:0] ready_w;
   logic [N-1:0] tx_w;
   logic [N-1:0] busy_w;

   int vectors     = 0;
   int miscompares = 0;

   // Reference: the frame currently on the line as a bit vector plus the cycle index within it.
   bit          act [N];
   int          t   [N];
   logic [12:0] fb  [N];
`ifdef UART_TX_FIFO_EN
   logic [8:0]  fq  [N][$];
`endif

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      uart_tx_cfg_if #(.DATA_BITS(DB[g])) bus ();
      assign bus.data   = data_d[g][DB[g]-1:0];
      assign bus.start  = start_d[g];
      assign ready_w[g] = bus.ready;
      uart_tx_cfg #(
         .CLK_DIV(CD[g]), .DATA_BITS(DB[g]), .PARITY(PA[g]),
         .STOP_BITS(SB[g]), .FIFO_DEPTH(FD)
      ) u_dut (
         .clk(clk), .rstn(rstn), .bus(bus), .tx_o(tx_w[g]), .busy_o(busy_w[g])
      );
   end

   function automatic int flen(int k);
      return (1 + DB[k] + ((PA[k] != 0) ? 1 : 0) + SB[k]) * CD[k];
   endfunction

   function automatic logic [12:0] frame_of(int k, logic [8:0] d);
      logic [12:0] f;
      int          ones;
      f    = '1;
      f[0] = 1'b0;
      ones = 0;
      for (int i = 0; i < DB[k]; i++) begin
         f[1+i] = d[i];
         ones  += int'(d[i]);
      end
      if (PA[k] == 1)      f[1+DB[k]] = ((ones % 2) == 0);
      else if (PA[k] == 2) f[1+DB[k]] = ((ones % 2) == 1);
      return f;
   endfunction

   task automatic model_edge();
      bit         free;
      bit         pop;
      bit         rdy;
      logic [8:0] w;
      for (int k = 0; k < N; k++) begin
         if (!rstn) begin
            act[k] = 1'b0;
            t[k]   = 0;
`ifdef UART_TX_FIFO_EN
            fq[k].delete();
`endif
         end else begin
            free = !act[k] || (t[k] == flen(k) - 1);
`ifdef UART_TX_FIFO_EN
            rdy = (fq[k].size() < FD);
            pop = free && (fq[k].size() > 0);
            w   = '0;
            if (pop) w = fq[k].pop_front();
            if (start_d[k] && rdy) fq[k].push_back(data_d[k]);
`else
            rdy = free;
            pop = start_d[k] && rdy;
            w   = data_d[k];
`endif
            if (pop) begin
               act[k] = 1'b1;
               t[k]   = 0;
               fb[k]  = frame_of(k, w);
            end else if (act[k]) begin
               if (t[k] == flen(k) - 1) act[k] = 1'b0;
               else                     t[k]++;
            end
         end
      end
   endtask

   task automatic chk(string nm, int k, logic got, logic exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s unit %0d at %0t: got %b want %b", nm, k, $time, got, exp);
      end
   endtask

   task automatic chk_int(string nm, int k, int got, int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s unit %0d at %0t: got 0x%0h want 0x%0h", nm, k, $time, got, exp);
      end
   endtask

   task automatic compare();
      logic e_tx;
      logic e_busy;
      logic e_rdy;
      for (int k = 0; k < N; k++) begin
         e_tx   = act[k] ? fb[k][t[k] / CD[k]] : 1'b1;
`ifdef UART_TX_FIFO_EN
         e_busy = act[k] || (fq[k].size() > 0);
         e_rdy  = (fq[k].size() < FD);
`else
         e_busy = act[k];
         e_rdy  = !act[k] || (t[k] == flen(k) - 1);
`endif
         chk("tx", k, tx_w[k], e_tx);
         chk("busy", k, busy_w[k], e_busy);
         chk("ready", k, ready_w[k], e_rdy);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask

   initial begin
      int          busy_cnt [N];
      logic [12:0] cap [N];
      int          acc_at;

      start_d = '0;
      for (int k = 0; k < N; k++) begin
         data_d[k] = '0;
         act[k]    = 1'b0;
         t[k]      = 0;
         fb[k]     = '1;
      end
      rstn = 1'b0;
      @(negedge clk);
      repeat (3) step();
      chk("rst_tx", 0, tx_w[0], 1'b1);
      chk("rst_busy", 0, busy_w[0], 1'b0);
      chk("rst_ready", 0, ready_w[0], 1'b1);
      rstn = 1'b1;
      step();

      // One frame per unit; data is scrambled afterwards to prove the word was latched.
      data_d[0] = 9'h0A5;
      data_d[1] = 9'h007;
      data_d[2] = 9'h007;
      data_d[3] = 9'h055;
      data_d[4] = 9'h1FF;
      start_d   = '1;
      step();
      start_d = '0;
      for (int k = 0; k < N; k++) begin
         busy_cnt[k] = 0;
         cap[k]      = '0;
      end
      for (int j = 0; j < 50; j++) begin
         for (int k = 0; k < N; k++) begin
            if ((j % CD[k]) == (CD[k] / 2) && (j / CD[k]) < 13) cap[k][j / CD[k]] = tx_w[k];
            busy_cnt[k] += int'(busy_w[k]);
            data_d[k]    = 9'($urandom);
         end
         step();
      end
      chk_int("frame_a5_8n1", 0, int'(cap[0][9:0]), 'h34A);
      chk_int("frame_07_even", 1, int'(cap[1][10:0]), 'h60E);
      chk_int("frame_07_odd", 2, int'(cap[2][10:0]), 'h40E);
      chk_int("frame_55_7n2", 3, int'(cap[3][9:0]), 'h3AA);
      chk_int("frame_1ff_9o2", 4, int'(cap[4][12:0]), 'h1BFE);
      for (int k = 0; k < N; k++) chk_int("busy_len", k, busy_cnt[k], BL[k]);

      // Back-to-back on unit 0: second word must be taken exactly in the final stop cycle.
      data_d[0]  = 9'h001;
      start_d[0] = 1'b1;
      step();
      data_d[0] = 9'h080;
      acc_at    = -1;
      for (int j = 0; j < 45 && acc_at < 0; j++) begin
         if (ready_w[0]) acc_at = j;
         step();
      end
      start_d[0] = 1'b0;
      chk_int("b2b_accept_cycle", 0, acc_at, 39);
      repeat (45) step();

      // Reset during data bit 3 of unit 0.
      data_d[0]  = 9'h0C3;
      start_d[0] = 1'b1;
      step();
      start_d[0] = 1'b0;
      repeat (17) step();
      rstn = 1'b0;
      step();
      chk("midrst_tx", 0, tx_w[0], 1'b1);
      chk("midrst_busy", 0, busy_w[0], 1'b0);
      chk("midrst_ready", 0, ready_w[0], 1'b1);
      rstn = 1'b1;

      for (int c = 0; c < 4000; c++) begin
         for (int k = 0; k < N; k++) begin
            start_d[k] = ($urandom_range(0, 2) == 0);
            data_d[k]  = 9'($urandom);
         end
         rstn = ($urandom_range(0, 999) != 0);
         step();
      end
      rstn    = 1'b1;
      start_d = '0;
      repeat (80) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
